// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with internal 16x baud tick generator.
// Ports: clk, reset (async, active high), tx_start/din request, tx line,
//        tx_done_tick end-of-frame pulse, busy while a frame is in flight.
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int M       = 163
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx,
    output logic       tx_done_tick,
    output logic       busy
);

    localparam int BW = $clog2(M);
    localparam int TW = $clog2(SB_TICK > 16 ? SB_TICK : 16);

    localparam logic [BW-1:0] B_LAST = BW'(M - 1);
    localparam logic [BW-1:0] B_PRE  = BW'(M - 2);
    localparam logic [TW-1:0] T_LAST = TW'(15);
    localparam logic [TW-1:0] T_STOP = TW'(SB_TICK - 1);
    localparam logic [2:0]    D_LAST = 3'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    logic [BW-1:0] b_cnt;
    logic [TW-1:0] t_cnt;
    logic [2:0]    n_cnt;
    logic [7:0]    sh;
    logic          s_tick;

    assign s_tick = (b_cnt == B_LAST);

    // Baud counter is parked at 0 in IDLE so every frame starts
    // with a full tick period after the acceptance edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_cnt <= '0;
        end else if (state == IDLE || s_tick) begin
            b_cnt <= '0;
        end else begin
            b_cnt <= b_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            t_cnt        <= '0;
            n_cnt        <= '0;
            sh           <= '0;
            tx           <= 1'b1;
            busy         <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            // Registered pulse is raised one clock early so it occupies
            // exactly the cycle that ends with the final stop tick.
            tx_done_tick <= (state == STOP) && (t_cnt == T_STOP)
                            && (b_cnt == B_PRE);
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_start) begin
                        sh    <= din;
                        t_cnt <= '0;
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (t_cnt == T_LAST) begin
                            t_cnt <= '0;
                            n_cnt <= '0;
                            state <= DATA;
                            tx    <= sh[0];
                        end else begin
                            t_cnt <= t_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (t_cnt == T_LAST) begin
                            t_cnt <= '0;
                            sh    <= sh >> 1;
                            if (n_cnt == D_LAST) begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end else begin
                                n_cnt <= n_cnt + 1'b1;
                                tx    <= sh[1];
                            end
                        end else begin
                            t_cnt <= t_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (t_cnt == T_STOP) begin
                            t_cnt <= '0;
                            // A request on the last stop edge starts the
                            // next frame with no idle gap.
                            if (tx_start) begin
                                sh    <= din;
                                state <= START;
                                tx    <= 1'b0;
                            end else begin
                                state <= IDLE;
                                tx    <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end else begin
                            t_cnt <= t_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    t_cnt <= '0;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx frame timing and control.
// Two instances: default stop bit and a two-stop-bit variant.
module tb_uart_tx;

    logic       clk;
    logic       reset;
    logic       tx_start;
    logic [7:0] din;
    logic       tx;
    logic       tx_done_tick;
    logic       busy;
    logic       tx_start2;
    logic [7:0] din2;
    logic       tx2;
    logic       done2;
    logic       busy2;

    int tests;
    int fails;

    uart_tx #(.DBIT(8), .SB_TICK(16), .M(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_start     (tx_start),
        .din          (din),
        .tx           (tx),
        .tx_done_tick (tx_done_tick),
        .busy         (busy)
    );

    uart_tx #(.DBIT(8), .SB_TICK(32), .M(2)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .tx_start     (tx_start2),
        .din          (din2),
        .tx           (tx2),
        .tx_done_tick (done2),
        .busy         (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level n clocks after acceptance (bit period 32).
    function automatic logic exp_tx(input logic [7:0] b, input int n,
                                    input int f);
        if (n < 0 || n >= f) return 1'b1;
        if (n < 32) return 1'b0;
        if (n < 288) return b[(n - 32) / 32];
        return 1'b1;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        tx_start = 1'b1;
        din = 8'hC3;
        repeat (3) @(negedge clk);
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_done_tick !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: tx=%b busy=%b done=%b want 1 0 0",
                     tx, busy, tx_done_tick);
        end
        tests++;
        if (tx2 !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0) begin
            fails++;
            $display("FAIL reset_state2: tx=%b busy=%b done=%b want 1 0 0",
                     tx2, busy2, done2);
        end
        reset = 1'b0;
        @(negedge clk);
        tx_start = 1'b0;
        tests++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL start_on_release: tx=%b busy=%b want 0 1",
                     tx, busy);
        end
        repeat (330) @(negedge clk);
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL release_frame_end: tx=%b busy=%b want 1 0",
                     tx, busy);
        end
    endtask

    task automatic test_basic;
        @(negedge clk);
        din = 8'hA5;
        tx_start = 1'b1;
        for (int n = 0; n <= 325; n++) begin
            @(negedge clk);
            if (n == 0) tx_start = 1'b0;
            tests++;
            if (tx !== exp_tx(8'hA5, n, 320)) begin
                fails++;
                $display("FAIL basic_tx n=%0d: got %b want %b",
                         n, tx, exp_tx(8'hA5, n, 320));
            end
            tests++;
            if (busy !== (n < 320)) begin
                fails++;
                $display("FAIL basic_busy n=%0d: got %b", n, busy);
            end
            tests++;
            if (tx_done_tick !== (n == 319)) begin
                fails++;
                $display("FAIL basic_done n=%0d: got %b", n, tx_done_tick);
            end
        end
    endtask

    task automatic test_busy_request;
        @(negedge clk);
        din = 8'h5A;
        tx_start = 1'b1;
        for (int n = 0; n <= 340; n++) begin
            @(negedge clk);
            if (n == 0) tx_start = 1'b0;
            if (n == 144) begin
                din = 8'h3C;
                tx_start = 1'b1;
            end
            if (n == 145) tx_start = 1'b0;
            tests++;
            if (tx !== exp_tx(8'h5A, n, 320)) begin
                fails++;
                $display("FAIL busy_req_tx n=%0d: got %b want %b",
                         n, tx, exp_tx(8'h5A, n, 320));
            end
            tests++;
            if (busy !== (n < 320) || tx_done_tick !== (n == 319)) begin
                fails++;
                $display("FAIL busy_req_ctl n=%0d: busy=%b done=%b",
                         n, busy, tx_done_tick);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic e;
        @(negedge clk);
        din = 8'hFF;
        tx_start = 1'b1;
        for (int n = 0; n <= 650; n++) begin
            @(negedge clk);
            if (n == 100) din = 8'h00;
            if (n == 320) tx_start = 1'b0;
            e = (n < 320) ? exp_tx(8'hFF, n, 320)
                          : exp_tx(8'h00, n - 320, 320);
            tests++;
            if (tx !== e) begin
                fails++;
                $display("FAIL b2b_tx n=%0d: got %b want %b", n, tx, e);
            end
            tests++;
            if (busy !== (n < 640)
                || tx_done_tick !== (n == 319 || n == 639)) begin
                fails++;
                $display("FAIL b2b_ctl n=%0d: busy=%b done=%b",
                         n, busy, tx_done_tick);
            end
        end
    endtask

    task automatic test_din_change;
        @(negedge clk);
        din = 8'h81;
        tx_start = 1'b1;
        for (int n = 0; n <= 322; n++) begin
            @(negedge clk);
            if (n == 0) begin
                tx_start = 1'b0;
                din = 8'h7E;
            end
            tests++;
            if (tx !== exp_tx(8'h81, n, 320)) begin
                fails++;
                $display("FAIL din_change_tx n=%0d: got %b want %b",
                         n, tx, exp_tx(8'h81, n, 320));
            end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        din = 8'h00;
        tx_start = 1'b1;
        for (int n = 0; n < 140; n++) begin
            @(negedge clk);
            if (n == 0) tx_start = 1'b0;
        end
        tests++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset: tx=%b busy=%b want 0 1", tx, busy);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: tx=%b busy=%b want 1 0", tx, busy);
        end
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            tests++;
            if (tx_done_tick !== 1'b0) begin
                fails++;
                $display("FAIL reset_no_done: got %b", tx_done_tick);
            end
        end
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            tests++;
            if (tx !== 1'b1 || busy !== 1'b0 || tx_done_tick !== 1'b0) begin
                fails++;
                $display("FAIL post_reset_idle: tx=%b busy=%b done=%b",
                         tx, busy, tx_done_tick);
            end
        end
        din = 8'h55;
        tx_start = 1'b1;
        for (int n = 0; n <= 322; n++) begin
            @(negedge clk);
            if (n == 0) tx_start = 1'b0;
            tests++;
            if (tx !== exp_tx(8'h55, n, 320)) begin
                fails++;
                $display("FAIL after_reset_tx n=%0d: got %b want %b",
                         n, tx, exp_tx(8'h55, n, 320));
            end
            tests++;
            if (busy !== (n < 320) || tx_done_tick !== (n == 319)) begin
                fails++;
                $display("FAIL after_reset_ctl n=%0d: busy=%b done=%b",
                         n, busy, tx_done_tick);
            end
        end
    endtask

    task automatic test_stop_bits;
        @(negedge clk);
        din2 = 8'h0F;
        tx_start2 = 1'b1;
        for (int n = 0; n <= 356; n++) begin
            @(negedge clk);
            if (n == 0) tx_start2 = 1'b0;
            tests++;
            if (tx2 !== exp_tx(8'h0F, n, 352)) begin
                fails++;
                $display("FAIL stop2_tx n=%0d: got %b want %b",
                         n, tx2, exp_tx(8'h0F, n, 352));
            end
            tests++;
            if (busy2 !== (n < 352) || done2 !== (n == 351)) begin
                fails++;
                $display("FAIL stop2_ctl n=%0d: busy=%b done=%b",
                         n, busy2, done2);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        tx_start = 1'b0;
        din = 8'h00;
        tx_start2 = 1'b0;
        din2 = 8'h00;
        test_reset;
        test_basic;
        test_busy_request;
        test_back_to_back;
        test_din_change;
        test_reset_mid;
        test_stop_bits;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the pipeline debug path. It accepts one byte per request from the debug byte-serializer stage (`r_data` / `flagTx`) and shifts it out on a single UART line as 8N1 frames, LSB first. It contains its own 16x-oversampling baud tick generator. The byte is captured on the request cycle, so the upstream byte may change immediately afterwards.

## Interface
- `DBIT`, default 8: data bits per frame; legal values 7 or 8.
- `SB_TICK`, default 16: oversampling ticks in the stop bit; 16, 24 or 32 give 1, 1.5 or 2 stop bits.
- `M`, default 163: clocks per oversampling tick (50 MHz / (19200 * 16)); legal range ≥ 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `tx_start` in 1: send request; sampled only in IDLE.
- `din` in 8: byte to send; bits [DBIT-1:0] are used; captured when the request is accepted.
- `tx` out 1: serial line, registered; idles high.
- `tx_done_tick` out 1: one-clock pulse at the end of the stop bit.
- `busy` out 1: high from acceptance until the frame ends.

## Operation
- Reset values: `tx`=1, `tx_done_tick`=0, `busy`=0, state=IDLE; baud counter, tick counter, bit counter and shift register all 0.
- Baud generator:
  - Counter 0..M-1; `s_tick`=1 when count==M-1, then wraps to 0.
  - Counter is held at 0 in IDLE and starts counting on the acceptance edge, so frame timing is deterministic.
- State machine (registered `tx` is driven per state):
  - IDLE (`tx`=1): if `tx_start`=1 at a rising edge, load shift register with `din`, clear tick counter, go to START, set `busy`=1.
  - START (`tx`=0): after 16 `s_tick`s, go to DATA with bit counter=0.
  - DATA (`tx`=shift[0]): after 16 `s_tick`s, shift right. If bit counter==DBIT-1, go to STOP; otherwise increment the bit counter.
  - STOP (`tx`=1): after SB_TICK `s_tick`s, pulse `tx_done_tick` for one clock, go to IDLE, set `busy`=0.
- Tick counter: 0..15 in START/DATA, 0..SB_TICK-1 in STOP; cleared on every state change.
- `tx_start` outside IDLE is ignored. The request is dropped, not queued, and `din` is not re-sampled mid-frame.
- `tx_start` held high continuously sends back-to-back frames of the current `din`.
- Unused or illegal state encodings go to IDLE with `tx`=1.

## Timing
- Bit period = 16*M clocks. Frame length = (16*(1+DBIT) + SB_TICK)*M clocks.
- Acceptance edge E0: `tx` falls at E0 (registered, visible after E0).
- Data bit k starts at E0 + 16*M*(1+k).
- Stop bit starts at E0 + 16*M*(1+DBIT).
- `tx_done_tick` is high for the single cycle ending at edge E0 + frame length; `busy` falls at that same edge.
- Minimum request gap: a new `tx_start` is accepted at the edge after `tx_done_tick`, so there is zero idle time between frames.
- Reset asserted mid-frame: `tx`=1 and `busy`=0 immediately (asynchronous); no `tx_done_tick`; the partial frame is abandoned.
- Reset released with `tx_start` already high: acceptance happens at the first rising edge after release.

## Test plan
- Basic frame (M=2, DBIT=8, SB_TICK=16): `din`=0xA5 with a 1-cycle `tx_start` → `tx` low 32 clocks, then 1,0,1,0,0,1,0,1 for 32 clocks each, then high 32 clocks. `tx_done_tick` fires at exactly 320 clocks after acceptance; `busy` is high for 320 clocks.
- Request while busy: second `tx_start` with `din`=0x3C at mid-data of a 0x5A frame → only 0x5A is transmitted, one `tx_done_tick`, `busy` drops at 320 clocks.
- Back-to-back: `tx_start` held high with `din`=0xFF, then 0x00 → two frames with no idle gap. The second start bit begins the edge after the first `tx_done_tick`; total 640 clocks.
- `din` change after capture: `din`=0x81 accepted, then `din`=0x7E on the next cycle → line carries 0x81.
- Reset mid-frame: assert `reset` in bit 3 of 0x00 → `tx`=1 and `busy`=0 within the same cycle, no done pulse. A new 0x55 request after release transmits a correct full frame.
- Stop-bit variant (SB_TICK=32, M=2): `din`=0x0F → stop bit 64 clocks high, `tx_done_tick` at 352 clocks.
